// File: rtl/fb_scan_arbiter.sv
// Framebuffer RAM owner: VGA scan-out prefetches always win the single port,
// the drawing engine gets every other slot. Also serialises words into pixels.
module fb_scan_arbiter #(
  parameter int HOR_FIELD      = 799,
  parameter int HOR_TOTAL      = 1042,
  parameter int VER_FIELD      = 599,
  parameter int VER_TOTAL      = 665,
  parameter int PIX_W          = 2,
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int WORDS_PER_LINE = (HOR_FIELD + 1) / (DATA_W / PIX_W),
  parameter int FB_WORDS       = WORDS_PER_LINE * (VER_FIELD + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       display_col,
  input  logic [10:0]       display_row,
  input  logic              calc,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_oob,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  pixel
);

  localparam int PPW     = DATA_W / PIX_W;
  localparam int LOG_PPW = $clog2(PPW);
  localparam int SEL_W   = $clog2(DATA_W);
  localparam int COL_W   = 12;
  localparam int ROW_W   = 11;

  localparam logic [COL_W-1:0]   COL_FIELD  = COL_W'(HOR_FIELD);
  localparam logic [COL_W-1:0]   COL_TOTAL  = COL_W'(HOR_TOTAL);
  localparam logic [COL_W-1:0]   COL_A_LIM  = COL_W'(HOR_FIELD + 1 - PPW);
  localparam logic [COL_W-1:0]   COL_B      = COL_W'(HOR_TOTAL - 4);
  localparam logic [ROW_W-1:0]   ROW_FIELD  = ROW_W'(VER_FIELD);
  localparam logic [ROW_W-1:0]   ROW_TOTAL  = ROW_W'(VER_TOTAL);
  localparam logic [LOG_PPW-1:0] SUB_MID    = LOG_PPW'(PPW / 2);
  localparam logic [LOG_PPW-1:0] SUB_LAST   = LOG_PPW'(PPW - 1);
  localparam logic [ADDR_W-1:0]  FB_LIM     = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0]  LINE_WORDS = ADDR_W'(WORDS_PER_LINE);

  logic [ROW_W-1:0]   next_row_s;
  logic [ROW_W-1:0]   rd_row_s;
  logic [LOG_PPW-1:0] col_sub_s;
  logic [SEL_W-1:0]   bit_sel_s;
  logic [ADDR_W-1:0]  rd_word_s;
  logic [ADDR_W-1:0]  rd_addr_s;
  logic               slot_a_s;
  logic               slot_b_s;
  logic               slot_s;
  logic               xfer_s;
  logic               visible_s;
  logic               calc_unused_s;

  logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
  logic               mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               wr_gnt_q,    wr_gnt_d;
  logic               wr_oob_q,    wr_oob_d;
  logic [PIX_W-1:0]   pixel_q,     pixel_d;
  logic [DATA_W-1:0]  cur_word_q,  cur_word_d;
  logic [DATA_W-1:0]  next_word_q, next_word_d;
  logic               fetch1_q,    fetch1_d;
  logic               fetch2_q,    fetch2_d;
  logic               synced_q,    synced_d;

  // vertical-blank flag is informational; scheduling is derived from row/col
  assign calc_unused_s = calc;

  // Scan-slot detection and the framebuffer address of the word it fetches
  always_comb begin
    col_sub_s  = display_col[LOG_PPW-1:0];
    next_row_s = (display_row == ROW_TOTAL) ? '0 : display_row + ROW_W'(1'b1);
    slot_a_s   = (display_row <= ROW_FIELD) && (display_col < COL_A_LIM) &&
                 (col_sub_s == SUB_MID);
    slot_b_s   = (display_col == COL_B) && (next_row_s <= ROW_FIELD);
    slot_s     = slot_a_s || slot_b_s;
    if (slot_b_s) begin
      rd_row_s  = next_row_s;
      rd_word_s = '0;
    end else begin
      rd_row_s  = display_row;
      rd_word_s = ADDR_W'(display_col[COL_W-1:LOG_PPW]) + ADDR_W'(1'b1);
    end
    rd_addr_s = ADDR_W'(rd_row_s) * LINE_WORDS + rd_word_s;
    xfer_s    = ((col_sub_s == SUB_LAST) && (display_col < COL_FIELD)) ||
                (display_col == COL_TOTAL);
    visible_s = (display_col <= COL_FIELD) && (display_row <= ROW_FIELD) && synced_q;
    bit_sel_s = SEL_W'(col_sub_s) * SEL_W'(PIX_W);
  end

  // Next-state: port arbitration, fetch pipeline, word transfer and pixel select
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_gnt_d    = 1'b0;
    wr_oob_d    = wr_oob_q;
    if (slot_s) begin
      mem_addr_d = rd_addr_s;
    end else if (wr_req) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_we_d    = (wr_addr < FB_LIM);
      wr_gnt_d    = 1'b1;
      wr_oob_d    = wr_oob_q || (wr_addr >= FB_LIM);
    end else begin
      mem_we_d = 1'b0;
      wr_gnt_d = 1'b0;
    end

    // RAM answers one cycle after the address; capture one cycle later still
    fetch1_d = slot_s;
    fetch2_d = fetch1_q;
    if (fetch2_q) begin
      next_word_d = mem_rdata;
    end else begin
      next_word_d = next_word_q;
    end
    if (xfer_s) begin
      cur_word_d = next_word_q;
    end else begin
      cur_word_d = cur_word_q;
    end

    // pixels stay dark after reset until a full line has been prefetched
    synced_d = synced_q || slot_b_s;
    if (visible_s) begin
      pixel_d = cur_word_q[bit_sel_s +: PIX_W];
    end else begin
      pixel_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_gnt_q    <= 1'b0;
      wr_oob_q    <= 1'b0;
      pixel_q     <= '0;
      cur_word_q  <= '0;
      next_word_q <= '0;
      fetch1_q    <= 1'b0;
      fetch2_q    <= 1'b0;
      synced_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_gnt_q    <= wr_gnt_d;
      wr_oob_q    <= wr_oob_d;
      pixel_q     <= pixel_d;
      cur_word_q  <= cur_word_d;
      next_word_q <= next_word_d;
      fetch1_q    <= fetch1_d;
      fetch2_q    <= fetch2_d;
      synced_q    <= synced_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_gnt    = wr_gnt_q;
  assign wr_oob    = wr_oob_q;
  assign pixel     = pixel_q;

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Owns the single-port synchronous framebuffer RAM.
- Shares the RAM between two users:
  - VGA scan-out reads, which always win and are paced by the 800x600 timing counters.
  - One writer requester (the drawing/calc engine), which takes every slot scan-out does not need.
- Sits between the VGA timing controller (display_col/display_row/calc) and the framebuffer.
- Produces the per-pixel colour index for the DAC stage.

Parameters:
HOR_FIELD, 799, last visible column
HOR_TOTAL, 1042, last column of a line
VER_FIELD, 599, last visible row
VER_TOTAL, 665, last row of a frame
PIX_W, 2, bits per pixel
DATA_W, 16, RAM word width; PPW = DATA_W/PIX_W pixels per word, power of 2, >= 4
WORDS_PER_LINE, 100, (HOR_FIELD+1)/PPW
ADDR_W, 16, RAM address width
FB_WORDS, 60000, WORDS_PER_LINE*(VER_FIELD+1)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high; clears all state
display_col  in  12  column from timing controller
display_row  in  11  row from timing controller
calc  in  1  vertical-blank indication (informational; scheduling uses row/col)
wr_req  in  1  writer request; held with addr/data until wr_gnt
wr_addr  in  ADDR_W  writer word address
wr_data  in  DATA_W  writer word
wr_gnt  out  1  one-cycle pulse: write accepted this cycle
wr_oob  out  1  sticky: a write with wr_addr >= FB_WORDS was accepted and dropped
mem_addr  out  ADDR_W  RAM address, registered
mem_we  out  1  RAM write enable, registered
mem_wdata  out  DATA_W  RAM write data, registered
mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_addr is presented
pixel  out  PIX_W  colour index, registered; 0 outside the visible field

Behaviour:
- Reset:
  - mem_addr = 0, mem_we = 0, mem_wdata = 0.
  - wr_gnt = 0, wr_oob = 0, pixel = 0.
  - cur_word = 0, next_word = 0, fetch-pending flags = 0.
  - Async assert; all registers update on the next clock edge after deassert.
- Scan slot: a cycle whose (display_col, display_row) satisfies either condition below.
  - Condition A:
    - display_row <= VER_FIELD
    - display_col < HOR_FIELD+1-PPW
    - display_col mod PPW == PPW/2
    - Fetch word (display_col/PPW)+1 of display_row.
  - Condition B:
    - display_col == HOR_TOTAL-4
    - next row visible (next = 0 if display_row == VER_TOTAL, else display_row+1; next <= VER_FIELD)
    - Fetch word 0 of next row.
- Read address = row*WORDS_PER_LINE + word, computed combinationally, no divider.
- Read pipeline:
  - At the edge ending the scan-slot cycle: mem_addr <= read address, mem_we <= 0.
  - Next edge: rdata returned by the RAM.
  - Following edge: next_word <= mem_rdata (capture flag delayed two cycles from the slot).
- Word transfer: cur_word <= next_word at the edge ending a cycle where either:
  - display_col mod PPW == PPW-1 and display_col < HOR_FIELD, or
  - display_col == HOR_TOTAL.
  - No transfer at col == HOR_FIELD.
- Pixel:
  - At each edge, pixel <= cur_word[(display_col mod PPW)*PIX_W +: PIX_W] when display_col <= HOR_FIELD and display_row <= VER_FIELD; else 0.
  - Fixed latency 1 clock after the col/row value; LSB pixel first.
- Writer arbitration, in any non-scan-slot cycle with wr_req = 1:
  - mem_addr <= wr_addr, mem_wdata <= wr_data.
  - mem_we <= (wr_addr < FB_WORDS).
  - wr_gnt <= 1.
  - wr_oob <= 1 if wr_addr >= FB_WORDS.
  - Otherwise wr_gnt <= 0 and mem_we <= 0.
  - Back-to-back grants are allowed: the writer may present a new request the cycle after wr_gnt.
  - Writer sees at most 1 stall cycle per PPW during visible lines, zero during vertical blank.
- Simultaneous scan slot and wr_req: scan wins; wr_gnt = 0; request stays pending.
- Row wrap: the prefetch at row VER_TOTAL, col HOR_TOTAL-4 targets row 0, word 0, address 0. Rows VER_FIELD..VER_TOTAL-1 issue no Condition-B fetch of invisible rows.
- Reset mid-frame: pixel stays 0 until the first Condition-B prefetch after release; wr_oob clears only on reset.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first assumed at the interface).

Test Plan:
- Reset values: hold reset, drive col/row/wr_req randomly -> all outputs 0. Release -> mem_we stays 0 until the first grant.
- First line:
  - Stimulus: RAM word 0 = 16'hE4E4, word 1 = 16'h1B1B; row 665 col 1038 -> row 0.
  - Required: mem_addr = 0 after col 1038; pixels for cols 0..7 = 0,1,2,3,0,1,2,3; cols 8..15 = 3,2,1,0,3,2,1,0.
- Contention:
  - Stimulus: wr_req held high across row 10, cols 0..15.
  - Required: wr_gnt low exactly at cols 4 and 12 (mem_addr = 1001, 1002); high every other cycle.
- Vertical blank:
  - Stimulus: 100 queued writes at row 620.
  - Required: 100 consecutive wr_gnt pulses; mem_we = 1 each cycle, addresses in order.
- Out of range: write wr_addr = 60000 -> wr_gnt = 1, mem_we = 0, wr_oob = 1 and stays 1.
- Boundary rows:
  - Row 599 col 1038 -> no read issued.
  - Row 598 col 1038 -> mem_addr = 59900.
  - Cols 800..1042 of a visible row -> pixel = 0.
